tmds_encoder: RTL and testbench
===============================

# tmds_encoder

Per-channel DVI/HDMI TMDS encoder: converts 8-bit pixel data (video period) or 2-bit control (blanking period) into 10-bit DC-balanced TMDS symbols. Sits directly upstream of the `tmds` serializer/buffer. It writes one symbol per accepted input into the serializer's symbol FIFO, honouring that FIFO's full flag. Three instances, one per colour channel, form the video transmit path.

## Interface
- `CTRL_RESET_SYMBOL`, default 10'b1101010100: symbol emitted for ctrl=2'b00. Informational; the value is fixed by DVI 1.0 and must not be overridden.
- `clk_i` in 1: pixel-rate clock, same domain as the serializer's symbol FIFO write side.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `valid_i` in 1: input word present this cycle.
- `ready_o` out 1: encoder accepts the input this cycle. Transfer occurs when `valid_i && ready_o`.
- `de_i` in 1: 1 = video data period, 0 = control period.
- `data_i` in 8: pixel data, used when `de_i`=1.
- `ctrl_i` in 2: {C1,C0}, used when `de_i`=0.
- `symbol_fifo_full_i` in 1: full flag from the serializer symbol FIFO.
- `write_symbol_o` out 1: write strobe to the FIFO.
- `symbol_o` out 10: TMDS symbol. Bit 0 is transmitted first.

## Operation
- Two-stage pipeline.
  - Stage 1 (S1) registers `de`, `ctrl`, and q_m[8:0].
  - Stage 2 (S2) registers the final symbol and updates the running disparity `cnt`.
- S1 transition minimization:
  - N1d = popcount(`data_i`), 0..8, 4 bits.
  - If N1d>4, or N1d==4 and `data_i`[0]==0: q_m[i] = XNOR chain and q_m[8]=0.
  - Otherwise: XOR chain and q_m[8]=1.
  - q_m[0] = `data_i`[0].
- S2 data path (de=1): N1 and N0 are counted over q_m[7:0].
  - If cnt==0 or N1==N0:
    - sym[9] = ~q_m[8]; sym[8] = q_m[8].
    - sym[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (N1−N0) : (N0−N1).
  - Else if (cnt>0 && N1>N0) or (cnt<0 && N0>N1):
    - sym = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (N0−N1).
  - Else:
    - sym = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·~q_m[8] + (N1−N0).
- S2 control path (de=0):
  - 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - cnt ← 0.
- `cnt` is a 5-bit signed two's-complement value. All difference arithmetic is done at 5 bits signed, and the reachable range is −8..+8.

## Timing
- `advance` = !s2_valid || !`symbol_fifo_full_i`.
- `ready_o` = `advance`. This is combinational, and the whole pipeline stalls as one unit.
- `write_symbol_o` = s2_valid && !`symbol_fifo_full_i`. This is combinational from the registered s2_valid.
- On `advance`:
  - S1 ← input, and s1_valid ← `valid_i`.
  - S2 ← S1, and s2_valid ← s1_valid.
  - `cnt` updates only when s1_valid is set.
- While stalled, S1, S2, `symbol_o` and `cnt` hold their values.
- Latency: an input accepted in cycle n gives `symbol_o` valid (s2_valid) in cycle n+2. Throughput is 1 symbol/cycle when the FIFO is not full.
- Reset values:
  - s1_valid = s2_valid = 0 and `cnt` = 0.
  - `symbol_o` = 10'b1101010100.
  - `write_symbol_o` = 0 and `ready_o` = 1.
- Reset mid-stream drops in-flight symbols. No partial write occurs, because the write strobe deasserts asynchronously with reset.
- `symbol_fifo_full_i` asserting in the same cycle that s2 holds data: no write occurs, and the symbol is held and written on the first non-full cycle. There is no duplication or loss.
- A bubble (`valid_i`=0) propagates as an invalid stage and does not touch `cnt`.

## Structure
- `tmds_pkg`:
  - the four control symbol constants;
  - the `CNT_W`=5 localparam;
  - a `popcount8` function.
- Sub-module `tmds_qm_encode`: combinational 8→9-bit transition minimization, instantiated in S1.
- `tmds_encoder` top: pipeline registers, handshake, disparity logic.

## Test plan
- Reset, then ctrl=00 with de=0 ×3, FIFO never full → three writes of 10'b1101010100 starting 2 cycles after the first accept; cnt=0.
- de=1, data 0x00 from cnt=0 → symbol 10'h100, cnt=−8. A second 0x00 → 10'h3FF, cnt=+2.
- de=1, data 0xFF → q_m=9'h0FF (XNOR path). Check the symbol and the cnt sign against the reference model over 10k random bytes; cnt must stay within −8..+8.
- `symbol_fifo_full_i` held 1 for 5 cycles with `valid_i`=1 → `ready_o`=0, no writes, `symbol_o` stable. On release, symbols appear in order with no loss or duplication.
- Data burst, then de=0 → cnt returns to 0, and the first data symbol after blanking encodes as if from cnt=0.
- `rst_ni` pulsed low with S1 and S2 full → `write_symbol_o` drops immediately, and the outputs show the reset values.

Source files
------------

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants and helpers for the TMDS encoder
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, d[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// rtl/tmds_encoder_if.sv - pixel input and symbol output bundles of the TMDS encoder

interface tmds_pix_if;
    logic       valid_i;
    logic       ready_o;
    logic       de_i;
    logic [7:0] data_i;
    logic [1:0] ctrl_i;

    modport master (output valid_i, output de_i, output data_i, output ctrl_i, input ready_o);
    modport slave  (input valid_i, input de_i, input data_i, input ctrl_i, output ready_o);
endinterface

interface tmds_sym_if;
    logic       symbol_fifo_full_i;
    logic       write_symbol_o;
    logic [9:0] symbol_o;

    modport master (input symbol_fifo_full_i, output write_symbol_o, output symbol_o);
    modport slave  (output symbol_fifo_full_i, input write_symbol_o, input symbol_o);
endinterface

// File: rtl/tmds_qm_encode.sv
// rtl/tmds_qm_encode.sv - 8 to 9 bit transition-minimizing stage
module tmds_qm_encode
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    logic [3:0] n1d;
    logic       use_xnor;

    // XNOR chain when the byte is one-heavy, otherwise XOR chain; bit 8 flags which
    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        q_m      = '0;
        q_m[0]   = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        end
        q_m[8] = !use_xnor;
    end

endmodule

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage DC-balanced TMDS channel encoder
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter logic [9:0] CTRL_RESET_SYMBOL = CTRL_00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    tmds_pix_if.slave  pix,
    tmds_sym_if.master sym
);

    logic                    advance;
    logic [8:0]              qm_d;

    logic                    s1_valid;
    logic                    s1_de;
    logic [1:0]              s1_ctrl;
    logic [8:0]              s1_qm;

    logic                    s2_valid;
    logic [9:0]              sym_q;
    logic signed [CNT_W-1:0] cnt_q;

    logic [9:0]              sym_d;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] n1_w;
    logic signed [CNT_W-1:0] n0_w;
    logic signed [CNT_W-1:0] diff;
    logic signed [CNT_W-1:0] two_q8;
    logic signed [CNT_W-1:0] two_nq8;
    logic                    q8;

    // Whole pipeline moves together; it only stalls when S2 holds a symbol the FIFO cannot take
    assign advance            = !s2_valid || !sym.symbol_fifo_full_i;
    assign pix.ready_o        = advance;
    assign sym.write_symbol_o = s2_valid && !sym.symbol_fifo_full_i;
    assign sym.symbol_o       = sym_q;

    tmds_qm_encode u_qm (
        .data (pix.data_i),
        .q_m  (qm_d)
    );

    // Disparity-controlled final symbol and next running disparity from the S1 contents
    always_comb begin
        q8      = s1_qm[8];
        n1_w    = {1'b0, popcount8(s1_qm[7:0])};
        n0_w    = 5'sd8 - n1_w;
        diff    = n1_w - n0_w;
        two_q8  = q8 ? 5'sd2 : 5'sd0;
        two_nq8 = q8 ? 5'sd0 : 5'sd2;
        sym_d   = CTRL_00;
        cnt_d   = '0;
        if (!s1_de) begin
            case (s1_ctrl)
                2'b00:   sym_d = CTRL_00;
                2'b01:   sym_d = CTRL_01;
                2'b10:   sym_d = CTRL_10;
                default: sym_d = CTRL_11;
            endcase
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            sym_d = {~q8, q8, (q8 ? s1_qm[7:0] : ~s1_qm[7:0])};
            cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) || ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            sym_d = {1'b1, q8, ~s1_qm[7:0]};
            cnt_d = cnt_q + two_q8 - diff;
        end else begin
            sym_d = {1'b0, q8, s1_qm[7:0]};
            cnt_d = cnt_q - two_nq8 + diff;
        end
    end

    // S1: capture the input word and its transition-minimized form
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_de    <= 1'b0;
            s1_ctrl  <= 2'b00;
            s1_qm    <= '0;
        end else if (advance) begin
            s1_valid <= pix.valid_i;
            s1_de    <= pix.de_i;
            s1_ctrl  <= pix.ctrl_i;
            s1_qm    <= qm_d;
        end
    end

    // S2: register the output symbol; bubbles pass through without touching disparity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            sym_q    <= CTRL_RESET_SYMBOL;
            cnt_q    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - self-checking bench for tmds_encoder
module tb_tmds_encoder;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    tmds_pix_if pix ();
    tmds_sym_if sym ();

    tmds_encoder dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pix    (pix.slave),
        .sym    (sym.master)
    );

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    typedef struct {
        logic [9:0] s;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] got[$];
    int         m_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_qm(input logic [7:0] d);
        logic [8:0] q;
        logic       xn;
        int         n;
        n    = $countones(d);
        xn   = (n > 4) || (n == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    task automatic model_enc(input logic de, input logic [7:0] d, input logic [1:0] c,
                             input int cin, output logic [9:0] s, output int cout);
        logic [8:0] q;
        logic [9:0] ctab [4];
        int         n1, n0, b8;
        ctab[0] = C00; ctab[1] = C01; ctab[2] = C10; ctab[3] = C11;
        if (!de) begin
            s    = ctab[c];
            cout = 0;
        end else begin
            q  = model_qm(d);
            b8 = q[8] ? 1 : 0;
            n1 = $countones(q[7:0]);
            n0 = 8 - n1;
            if (cin == 0 || n1 == n0) begin
                s    = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
                cout = cin + (q[8] ? (n1 - n0) : (n0 - n1));
            end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
                s    = {1'b1, q[8], ~q[7:0]};
                cout = cin + 2 * b8 + (n0 - n1);
            end else begin
                s    = {1'b0, q[8], q[7:0]};
                cout = cin - 2 * (1 - b8) + (n1 - n0);
            end
        end
    endtask

    // Scoreboard: model each accepted word, compare each FIFO write against it
    always @(negedge clk_i) begin
        exp_t e;
        int   dcnt;
        if (!rst_ni) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (sym.write_symbol_o) begin
                got.push_back(sym.symbol_o);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e    = exp_q.pop_front();
                    dcnt = int'($signed(dut.cnt_q));
                    chk("stream_symbol", sym.symbol_o, e.s);
                    chk("stream_cnt", dcnt, e.c);
                    chk("cnt_in_range", (dcnt >= -8 && dcnt <= 8) ? 1 : 0, 1);
                end
            end
            if (pix.valid_i && pix.ready_o) begin
                model_enc(pix.de_i, pix.data_i, pix.ctrl_i, m_cnt, e.s, e.c);
                m_cnt = e.c;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic de, input logic [7:0] d, input logic [1:0] c);
        pix.valid_i = 1'b1;
        pix.de_i    = de;
        pix.data_i  = d;
        pix.ctrl_i  = c;
        step();
        pix.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        pix.valid_i = 1'b0;
        sym.symbol_fifo_full_i = 1'b0;
        repeat (3) step();
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [9:0] last_got(input int back);
        if (got.size() <= back) return 10'bx;
        return got[got.size() - 1 - back];
    endfunction

    initial begin
        logic [9:0] s;
        logic [9:0] snap;
        int         c;

        pix.valid_i = 1'b0;
        pix.de_i    = 1'b0;
        pix.data_i  = 8'h00;
        pix.ctrl_i  = 2'b00;
        sym.symbol_fifo_full_i = 1'b0;

        // model pins
        chk("pin_qm_ff", model_qm(8'hFF), 9'h0FF);
        chk("pin_qm_00", model_qm(8'h00), 9'h100);
        model_enc(1'b1, 8'h00, 2'b00, 0, s, c);
        chk("pin_enc00_sym", s, 10'h100);
        chk("pin_enc00_cnt", c, -8);
        model_enc(1'b1, 8'h00, 2'b00, -8, s, c);
        chk("pin_enc00b_sym", s, 10'h3FF);
        chk("pin_enc00b_cnt", c, 2);

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", pix.ready_o, 1);
        chk("rst_write", sym.write_symbol_o, 0);
        chk("rst_symbol", sym.symbol_o, C00);
        rst_ni = 1'b1;
        step();

        // three control 00 words, write begins two cycles after first accept
        pix.valid_i = 1'b1; pix.de_i = 1'b0; pix.ctrl_i = 2'b00;
        step();
        chk("lat_no_write_yet", sym.write_symbol_o, 0);
        step();
        chk("lat_write_n2", sym.write_symbol_o, 1);
        chk("lat_symbol", sym.symbol_o, C00);
        step();
        drain();
        chk("ctrl_w0", last_got(2), C00);
        chk("ctrl_w1", last_got(1), C00);
        chk("ctrl_w2", last_got(0), C00);
        chk("ctrl_cnt", int'($signed(dut.cnt_q)), 0);

        // 0x00 twice then 0xFF
        send(1'b1, 8'h00, 2'b00);
        send(1'b1, 8'h00, 2'b00);
        send(1'b1, 8'hFF, 2'b00);
        drain();
        chk("d00_first", last_got(2), 10'h100);
        chk("d00_second", last_got(1), 10'h3FF);
        chk("dff_sym", last_got(0), 10'h200);
        chk("dff_cnt", int'($signed(dut.cnt_q)), -6);

        // stall: fill pipe, hold FIFO full for 5 cycles with input offered
        pix.valid_i = 1'b1; pix.de_i = 1'b1; pix.data_i = 8'h35;
        step();
        pix.data_i = 8'hA7;
        step();
        pix.data_i = 8'h5C;
        sym.symbol_fifo_full_i = 1'b1;
        @(negedge clk_i);
        snap = sym.symbol_o;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("stall_ready", pix.ready_o, 0);
            chk("stall_write", sym.write_symbol_o, 0);
            chk("stall_symbol", sym.symbol_o, snap);
        end
        step();
        sym.symbol_fifo_full_i = 1'b0;
        step();
        pix.valid_i = 1'b0;
        drain();

        // data burst, blanking, then data restarts from zero disparity
        send(1'b1, 8'h00, 2'b00);
        send(1'b1, 8'h0F, 2'b00);
        send(1'b1, 8'h81, 2'b00);
        send(1'b0, 8'h00, 2'b01);
        send(1'b1, 8'h00, 2'b00);
        drain();
        chk("blank_sym", last_got(1), C01);
        chk("after_blank_sym", last_got(0), 10'h100);
        chk("after_blank_cnt", int'($signed(dut.cnt_q)), -8);

        // random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            pix.valid_i = ($urandom_range(0, 9) < 8);
            pix.de_i    = ($urandom_range(0, 9) < 8);
            pix.data_i  = 8'($urandom);
            pix.ctrl_i  = 2'($urandom);
            sym.symbol_fifo_full_i = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();

        // reset with both stages full
        pix.valid_i = 1'b1; pix.de_i = 1'b1; pix.data_i = 8'h12;
        step();
        pix.data_i = 8'h34;
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_write", sym.write_symbol_o, 0);
        chk("midrst_symbol", sym.symbol_o, C00);
        chk("midrst_ready", pix.ready_o, 1);
        pix.valid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        repeat (4) step();
        chk("postrst_idle_write", sym.write_symbol_o, 0);
        send(1'b1, 8'h00, 2'b00);
        drain();
        chk("postrst_sym", last_got(0), 10'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
